waveform_capture: RTL

WAVEFORM_CAPTURE -- requirements
Module: waveform_capture

---
 rtl/waveform_capture.sv | 129 ++++++++++++
 1 files changed

// File: rtl/waveform_capture.sv
// Threshold-triggered single-shot waveform capture with a readout hold window.
// Define WAVEFORM_CAPTURE_TRIGGER_EN for rising-edge threshold triggering; otherwise free-run.
module waveform_capture #(
  parameter int unsigned NSAMPLES    = 500,
  parameter logic [13:0] THRESHOLD   = 14'd8192,
  parameter int unsigned HOLD_CYCLES = 20000,
  parameter bit          AUTO_REARM  = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [13:0] adc_data,
  input  logic        adc_valid,
  input  logic        arm,
  output logic [13:0] waveform [NSAMPLES],
  output logic        acquire,
  output logic [8:0]  sample_count,
  output logic [1:0]  state,
  output logic        capture_done
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ARMED   = 2'd1,
    S_CAPTURE = 2'd2,
    S_HOLD    = 2'd3
  } state_t;

  localparam int unsigned   HCW       = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HCW-1:0] HOLD_LAST = HCW'(HOLD_CYCLES - 1);
  localparam logic [8:0]    LAST_IDX  = 9'(NSAMPLES - 1);

  state_t         r_state;
  state_t         w_next_state;
  logic [8:0]     r_sample_count;
  logic [8:0]     w_count_next;
  logic           r_acquire;
  logic           r_capture_done;
  logic [HCW-1:0] r_hold_cnt;
  logic           w_trigger;
  logic           w_wr_en;
  logic [8:0]     w_wr_idx;
  logic [13:0]    r_wave [NSAMPLES];

`ifdef WAVEFORM_CAPTURE_TRIGGER_EN
  logic [13:0] r_prev;
  logic        r_primed;

  // Priming is forgotten whenever ARMED is left, so every arming needs a fresh baseline.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_prev   <= '0;
      r_primed <= 1'b0;
    end else if (r_state != S_ARMED) begin
      r_primed <= 1'b0;
    end else if (adc_valid) begin
      r_prev   <= adc_data;
      r_primed <= 1'b1;
    end
  end

  assign w_trigger = (r_state == S_ARMED) && adc_valid && r_primed &&
                     (r_prev < THRESHOLD) && (adc_data >= THRESHOLD);
`else
  assign w_trigger = (r_state == S_ARMED) && adc_valid;
`endif

  always_comb begin
    w_next_state = r_state;
    w_count_next = r_sample_count;
    w_wr_en      = 1'b0;
    w_wr_idx     = r_sample_count;
    case (r_state)
      S_IDLE: begin
        if (arm) w_next_state = S_ARMED;
      end
      S_ARMED: begin
        if (w_trigger) begin
          w_wr_en      = 1'b1;
          w_wr_idx     = '0;
          w_count_next = 9'd1;
          w_next_state = (NSAMPLES == 1) ? S_HOLD : S_CAPTURE;
        end
      end
      S_CAPTURE: begin
        if (adc_valid) begin
          w_wr_en      = 1'b1;
          w_count_next = r_sample_count + 9'd1;
          if (r_sample_count == LAST_IDX) w_next_state = S_HOLD;
        end
      end
      S_HOLD: begin
        if (r_hold_cnt == HOLD_LAST) begin
          w_count_next = '0;
          w_next_state = AUTO_REARM ? S_ARMED : S_IDLE;
        end
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state        <= S_IDLE;
      r_sample_count <= '0;
      r_acquire      <= 1'b1;
      r_capture_done <= 1'b0;
      r_hold_cnt     <= '0;
    end else begin
      r_state        <= w_next_state;
      r_sample_count <= w_count_next;
      r_acquire      <= (w_next_state != S_HOLD);
      r_capture_done <= (w_next_state == S_HOLD) && (r_state != S_HOLD);
      r_hold_cnt     <= ((r_state == S_HOLD) && (w_next_state == S_HOLD)) ?
                        r_hold_cnt + 1'b1 : '0;
    end
  end

  // Sample storage deliberately has no reset so it maps onto plain RAM.
  always_ff @(posedge clk) begin
    if (w_wr_en) r_wave[w_wr_idx] <= adc_data;
  end

  assign waveform     = r_wave;
  assign acquire      = r_acquire;
  assign sample_count = r_sample_count;
  assign state        = r_state;
  assign capture_done = r_capture_done;

endmodule
